pong_match_ctrl: RTL
====================

PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

Interface
REQ-001 BALLS, 3, balls per game in ball-limit mode (1..255).
REQ-002 SCORE_W, 4, width of each score counter.
REQ-003 WIN_SCORE, 5, target score in first-to mode (must be < 2^SCORE_W).
REQ-004 MODE, 0, 0 = ball-limit game, 1 = first-to-WIN_SCORE game.
REQ-005 WAIT_FRAMES, 120, frame ticks of serve/game-over delay (>= 1, fits 8 bits).
REQ-006 clk  input  1  system clock, 100 MHz.
REQ-007 reset  input  1  reset, asynchronous, active-high.
REQ-008 frame_tick  input  1  one-cycle pulse per video frame (x==0, y==0).
REQ-009 start  input  1  level, OR of all player buttons.
REQ-010 pause  input  1  level, pause key.
REQ-011 miss1, miss2  input  1 each  one-cycle pulses, player 1 / player 2 missed ball.
REQ-012 gra_still  output  1  freeze graphics.
REQ-013 state  output  3  current state code.
REQ-014 score1, score2  output  SCORE_W each  player scores.
REQ-015 balls_left  output  8  balls remaining.
REQ-016 winner  output  2  00 none, 01 P1, 10 P2, 11 draw.
REQ-017 serve_side  output  1  0 = P1 serves, 1 = P2 serves.
REQ-018 over_pulse  output  1  one-cycle pulse on entering OVER.

Function
REQ-019 States SHALL be IDLE=0, SERVE=1, PLAY=2, PAUSE=3, OVER=4; codes 5-7 SHALL return to IDLE next cycle.
REQ-020 Start event and pause event SHALL be rising edges of start/pause, detected with one register each.
REQ-021 IDLE: score1=score2=0, balls_left=BALLS, winner=00 held; start event -> PLAY next cycle.
REQ-022 gra_still SHALL be 0 only in PLAY, 1 otherwise.
REQ-023 PLAY, miss1 only: score2 += 1; miss2 only: score1 += 1; both same cycle: no score change, counted as one miss.
REQ-024 Scores SHALL saturate at 2^SCORE_W-1; balls_left SHALL saturate at 0.
REQ-025 PLAY, any miss: balls_left -= 1, timer loaded with WAIT_FRAMES, serve_side = 0 if miss1 only, 1 if miss2 only, toggled if both.
REQ-026 End test on post-update values: MODE=0 -> OVER when balls_left reaches 0; MODE=1 -> OVER when either score >= WIN_SCORE; else -> SERVE.
REQ-027 PLAY, pause event with no miss -> PAUSE; a miss in the same cycle SHALL take priority and the pause event SHALL be discarded.
REQ-028 PAUSE: misses ignored, scores/timer frozen; pause event -> PLAY.
REQ-029 SERVE: timer decrements on each frame_tick while nonzero; start event with timer==0 -> PLAY; start events while timer!=0 discarded.
REQ-030 OVER entry: winner = larger score, 11 if equal; over_pulse high exactly one cycle.
REQ-031 OVER: timer counts down as in SERVE; timer==0 -> IDLE; winner held until IDLE.
REQ-032 miss1/miss2 outside PLAY SHALL have no effect.
REQ-033 All outputs SHALL be registered; state change latency one clk after triggering input.

Reset
REQ-034 Reset: state=IDLE, scores 0, balls_left=BALLS, winner=00, serve_side=0, over_pulse=0, gra_still=1, timer 0.
REQ-035 Edge-detect registers SHALL reset to 1, so a button held through reset produces no event.
REQ-036 Reset asserted mid-game SHALL return to IDLE immediately, discarding scores.

Structure
REQ-037 State codes, winner codes and serve_side encodings SHALL live in shared package/include pong_pkg.
REQ-038 Delay counter SHALL be sub-module frame_timer (load, frame_tick decrement, zero flag).

Verification
REQ-039 MODE=0, BALLS=3, WAIT_FRAMES=2: start, miss1 x3 with starts between -> score2=3, balls_left=0, OVER, winner=10, over_pulse once, IDLE after 2 frame_ticks.
REQ-040 MODE=1, WIN_SCORE=2: miss2, serve, miss2 -> score1=2, OVER, winner=01.
REQ-041 miss1 and miss2 same cycle in PLAY -> scores unchanged, balls_left-1, serve_side toggled.
REQ-042 SERVE with timer=2: start before 2 frame_ticks ignored; start after -> PLAY.
REQ-043 PLAY: pause edge -> PAUSE, miss1 ignored, pause edge -> PLAY; pause+miss1 same cycle -> SERVE, score2+1.
REQ-044 start held across reset release -> stays IDLE; SCORE_W=2 with 4 misses -> score saturates at 3.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared encodings for the pong match controller: state codes, winner codes
// and serve-side values.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

  localparam logic SIDE_P1 = 1'b0;
  localparam logic SIDE_P2 = 1'b1;

endpackage

// File: rtl/frame_timer.sv
// Frame-tick delay counter for serve and game-over waits.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   load         - load counter with load_val (takes priority)
//   load_val     - value to load
//   en           - allow decrementing
//   tick         - frame tick; decrements while enabled and nonzero
//   zero         - counter is zero
module frame_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  input  logic       tick,
  output logic       zero
);

  logic [7:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && tick && (count != '0))
      count <= count - 8'd1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match controller: sequences idle/serve/play/pause/game-over, keeps
// saturating scores and the ball budget, picks the serving side and winner.
// Ports:
//   clk, reset       - clock, asynchronous active-high reset
//   frame_tick       - one pulse per video frame
//   start, pause     - button levels (rising edges are events)
//   miss1, miss2     - player 1 / player 2 missed the ball (pulses)
//   gra_still        - freeze graphics (low only while playing)
//   state            - current state code
//   score1, score2   - player scores
//   balls_left       - balls remaining
//   winner           - 00 none, 01 P1, 10 P2, 11 draw
//   serve_side       - 0 = P1 serves, 1 = P2 serves
//   over_pulse       - one-cycle pulse on entering game over
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int BALLS       = 3,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 5,
  parameter int MODE        = 0,
  parameter int WAIT_FRAMES = 120
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               pause,
  input  logic               miss1,
  input  logic               miss2,
  output logic               gra_still,
  output logic [2:0]         state,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [7:0]         balls_left,
  output logic [1:0]         winner,
  output logic               serve_side,
  output logic               over_pulse
);

  localparam logic [SCORE_W-1:0] WIN_S  = WIN_SCORE[SCORE_W-1:0];
  localparam logic [7:0]         BALLS_B = BALLS[7:0];
  localparam logic [7:0]         WAIT_B  = WAIT_FRAMES[7:0];

  state_t             cur, state_n;
  winner_t            win_q, win_n;
  logic [SCORE_W-1:0] score1_n, score2_n;
  logic [7:0]         balls_n;
  logic               serve_n, over_n, still_n;
  logic               start_q, pause_q;
  logic               start_ev, pause_ev;
  logic               any_miss, game_end, load, timer_zero;

  assign start_ev = start & ~start_q;
  assign pause_ev = pause & ~pause_q;
  assign any_miss = miss1 | miss2;

  frame_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (WAIT_B),
    .en       ((cur == ST_SERVE) || (cur == ST_OVER)),
    .tick     (frame_tick),
    .zero     (timer_zero)
  );

  always_comb begin
    state_n  = cur;
    score1_n = score1;
    score2_n = score2;
    balls_n  = balls_left;
    win_n    = win_q;
    serve_n  = serve_side;
    over_n   = 1'b0;
    load     = 1'b0;
    game_end = 1'b0;
    case (cur)
      ST_IDLE:  if (start_ev) state_n = ST_PLAY;
      ST_PLAY: begin
        // A miss outranks a same-cycle pause event, which is simply dropped.
        if (any_miss) begin
          if (miss1 && !miss2 && (score2 != '1)) score2_n = score2 + 1'b1;
          if (miss2 && !miss1 && (score1 != '1)) score1_n = score1 + 1'b1;
          if (balls_left != '0) balls_n = balls_left - 8'd1;
          load = 1'b1;
          if (miss1 && miss2) serve_n = ~serve_side;
          else                serve_n = miss2 ? SIDE_P2 : SIDE_P1;
          if (MODE == 0) game_end = (balls_n == '0);
          else           game_end = (score1_n >= WIN_S) || (score2_n >= WIN_S);
          if (game_end) begin
            state_n = ST_OVER;
            over_n  = 1'b1;
            if (score1_n > score2_n)      win_n = WIN_P1;
            else if (score2_n > score1_n) win_n = WIN_P2;
            else                          win_n = WIN_DRAW;
          end else begin
            state_n = ST_SERVE;
          end
        end else if (pause_ev) begin
          state_n = ST_PAUSE;
        end
      end
      ST_PAUSE: if (pause_ev) state_n = ST_PLAY;
      ST_SERVE: if (start_ev && timer_zero) state_n = ST_PLAY;
      ST_OVER:  if (timer_zero) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
    // Match bookkeeping is cleared on the same edge that enters idle so the
    // registered outputs already read zero while idle is shown.
    if (state_n == ST_IDLE) begin
      score1_n = '0;
      score2_n = '0;
      balls_n  = BALLS_B;
      win_n    = WIN_NONE;
    end
    still_n = (state_n != ST_PLAY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur        <= ST_IDLE;
      score1     <= '0;
      score2     <= '0;
      balls_left <= BALLS_B;
      win_q      <= WIN_NONE;
      serve_side <= SIDE_P1;
      over_pulse <= 1'b0;
      gra_still  <= 1'b1;
      start_q    <= 1'b1;
      pause_q    <= 1'b1;
    end else begin
      cur        <= state_n;
      score1     <= score1_n;
      score2     <= score2_n;
      balls_left <= balls_n;
      win_q      <= win_n;
      serve_side <= serve_n;
      over_pulse <= over_n;
      gra_still  <= still_n;
      start_q    <= start;
      pause_q    <= pause;
    end
  end

  assign state  = cur;
  assign winner = win_q;

endmodule
